// File: rtl/mem_bus_ctrl.sv
// External memory bus controller: sequences ALE/nME/nOE/RnW/ENB for single
// read/write accesses on a multiplexed address/data bus, with programmable
// wait states, nWait stretching and a timeout that ends the access with RspErr.
module mem_bus_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned WS_W    = 4,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              ReqValid,
  input  logic              ReqWrite,
  input  logic [DATA_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqWData,
  input  logic [WS_W-1:0]   WaitCfg,
  output logic              ReqReady,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspData,
  output logic              RspErr,
  output logic [DATA_W-1:0] Data_out,
  input  logic [DATA_W-1:0] Data_in,
  output logic              ALE,
  output logic              nME,
  output logic              nOE,
  output logic              RnW,
  output logic              ENB,
  input  logic              nWait,
  output logic              Busy
);

  localparam bit              TimeoutEn = (TIMEOUT != 0);
  // Last stretch cycle before abort; unused when the timeout is disabled.
  localparam logic [TO_W-1:0] ToLast    = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StAccess, StEnd} state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [WS_W-1:0]   wcnt_q, wcnt_d;
  logic [TO_W-1:0]   tocnt_q, tocnt_d;
  logic              err_q, err_d;

  // Next-state logic: request capture, wait-state countdown, stretch/timeout.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wcnt_d  = wcnt_q;
    tocnt_d = tocnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (ReqValid) begin
          write_d = ReqWrite;
          addr_d  = ReqAddr;
          wdata_d = ReqWData;
          wcnt_d  = WaitCfg;
          tocnt_d = '0;
          err_d   = 1'b0;
          state_d = StAddr;
        end
      end
      StAddr: state_d = StAccess;
      StAccess: begin
        if (wcnt_q != '0) begin
          // Programmed wait states run unconditionally; nWait is not looked at.
          wcnt_d = wcnt_q - WS_W'(1);
        end else if (nWait) begin
          if (!write_q) rdata_d = Data_in;
          err_d   = 1'b0;
          state_d = StEnd;
        end else begin
          if (tocnt_q != '1) tocnt_d = tocnt_q + TO_W'(1);
          if (TimeoutEn && (tocnt_q == ToLast)) begin
            err_d   = 1'b1;
            state_d = StEnd;
          end
        end
      end
      StEnd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wcnt_q  <= '0;
      tocnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wcnt_q  <= wcnt_d;
      tocnt_q <= tocnt_d;
      err_q   <= err_d;
    end
  end

  // Moore output decode from registered state only.
  always_comb begin
    ReqReady = 1'b0;
    Busy     = 1'b1;
    ALE      = 1'b0;
    nME      = 1'b1;
    nOE      = 1'b1;
    RnW      = 1'b1;
    ENB      = 1'b0;
    Data_out = '0;
    RspValid = 1'b0;
    RspErr   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ReqReady = 1'b1;
        Busy     = 1'b0;
      end
      StAddr: begin
        ALE      = 1'b1;
        ENB      = 1'b1;
        Data_out = addr_q;
      end
      StAccess: begin
        nME = 1'b0;
        if (write_q) begin
          RnW      = 1'b0;
          ENB      = 1'b1;
          Data_out = wdata_q;
        end else begin
          nOE = 1'b0;
        end
      end
      StEnd: begin
        RspValid = 1'b1;
        RspErr   = err_q;
        // Writes keep driving the data one extra cycle for hold time.
        if (write_q) begin
          ENB      = 1'b1;
          Data_out = wdata_q;
        end
      end
      default: begin
        ReqReady = 1'b0;
      end
    endcase
  end

  assign RspData = rdata_q;

endmodule
